// File: rtl/corr_peak_detect_pkg.sv
// Shared types and widths for the correlator peak detector.
package corr_pkg;

  localparam int MAG_W = 33;  // |I| + |Q| of two signed 32-bit values
  localparam int GAP_W = 8;   // saturating sample-gap counter
  localparam int CNT_W = 4;   // saturating well-spaced peak run length

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    DETECTED = 2'd2
  } state_t;

  // Absolute value of a signed 32-bit sample, widened to MAG_W bits so that
  // the most negative value maps to +2^31 without wrapping or saturating.
  function automatic logic [MAG_W-1:0] abs_ext(input logic [31:0] x);
    logic [MAG_W-1:0] xe;
    xe = {x[31], x};
    return x[31] ? (MAG_W'(0) - xe) : xe;
  endfunction

endpackage

// File: rtl/cplx_abs_sum.sv
// Registered |I| + |Q| magnitude stage with a valid flag travelling alongside.
module cplx_abs_sum
  import corr_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [63:0]      sum_in,
  input  logic             sum_strobe,
  output logic [MAG_W-1:0] mag,
  output logic             mag_valid
);

  logic [MAG_W-1:0] mag_reg;
  logic             mag_valid_reg;
  logic [MAG_W-1:0] mag_next;

  // Sum of the two absolute values; each is at most 2^31, so 33 bits suffice.
  assign mag_next = abs_ext(sum_in[63:32]) + abs_ext(sum_in[31:0]);

  // Capture a new magnitude on each strobe; a flush drops any in-flight valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mag_reg       <= '0;
      mag_valid_reg <= 1'b0;
    end else if (clear) begin
      mag_valid_reg <= 1'b0;
    end else if (enable) begin
      mag_valid_reg <= sum_strobe;
      if (sum_strobe) begin
        mag_reg <= mag_next;
      end
    end
  end

  assign mag       = mag_reg;
  assign mag_valid = mag_valid_reg;

endmodule

// File: rtl/corr_peak_detect.sv
// Peak finder and preamble detector on the correlator magnitude stream:
// local-maximum search above a threshold, peak-spacing tracking, sticky detect.
module corr_peak_detect
  import corr_pkg::*;
#(
  parameter int PEAK_GAP  = 16,
  parameter int GAP_TOL   = 1,
  parameter int MIN_PEAKS = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [31:0]      threshold,
  input  logic [63:0]      sum_in,
  input  logic             sum_strobe,
  output logic             peak_strobe,
  output logic [MAG_W-1:0] peak_mag,
  output logic [CNT_W-1:0] peak_count,
  output logic             detected
);

  localparam logic [GAP_W:0]   GAP_LO  = (GAP_W+1)'(PEAK_GAP - GAP_TOL);
  localparam logic [GAP_W:0]   GAP_HI  = (GAP_W+1)'(PEAK_GAP + GAP_TOL);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PEAKS);

  // Startup guard: the first edge after reset release ignores sum_strobe.
  logic armed_reg;
  logic strobe_in;

  // Magnitude stage outputs
  logic [MAG_W-1:0] mag;
  logic             mag_valid;

  // History and gap counter
  logic [MAG_W-1:0] m1_reg;
  logic [MAG_W-1:0] m2_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [GAP_W-1:0] gap_next;
  logic [GAP_W:0]   cand_gap;

  // Decision terms
  logic process;
  logic is_peak;
  logic gap_in_range;
  logic gap_timeout;

  // FSM and registered outputs
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] peak_count_reg;
  logic [CNT_W-1:0] peak_count_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             detected_reg;
  logic             detected_next;
  logic             peak_strobe_reg;
  logic [MAG_W-1:0] peak_mag_reg;

  // Arm the input one edge after reset release so a strobe in that cycle is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

  assign strobe_in = sum_strobe & armed_reg;

  cplx_abs_sum u_abs (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .sum_in     (sum_in),
    .sum_strobe (strobe_in),
    .mag        (mag),
    .mag_valid  (mag_valid)
  );

  // A new magnitude is consumed only while enabled; clear is handled in the registers.
  assign process  = enable & mag_valid;
  assign cand_gap = {1'b0, gap_cnt_reg} + (GAP_W+1)'(1);

  // m1 is a peak when above threshold, not below its predecessor and strictly
  // above its successor; a plateau therefore peaks on its last sample.
  assign is_peak = process
                 && (m1_reg > {1'b0, threshold})
                 && (m1_reg >= m2_reg)
                 && (m1_reg > mag);

  assign gap_in_range = (cand_gap >= GAP_LO) && (cand_gap <= GAP_HI);
  assign gap_timeout  = process && !is_peak && (cand_gap > GAP_HI);

  assign gap_next = is_peak              ? '0 :
                    (gap_cnt_reg == '1)  ? gap_cnt_reg :
                    gap_cnt_reg + GAP_W'(1);

  assign cnt_inc = (peak_count_reg == '1) ? peak_count_reg
                                          : peak_count_reg + CNT_W'(1);

  // Shift the two-deep magnitude history and advance the gap counter per sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m1_reg      <= '0;
      m2_reg      <= '0;
      gap_cnt_reg <= '0;
    end else if (clear) begin
      m1_reg      <= '0;
      m2_reg      <= '0;
      gap_cnt_reg <= '0;
    end else if (process) begin
      m2_reg      <= m1_reg;
      m1_reg      <= mag;
      gap_cnt_reg <= gap_next;
    end
  end

  // Peak strobe pulses for one enabled cycle; the peak magnitude survives clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_strobe_reg <= 1'b0;
      peak_mag_reg    <= '0;
    end else if (clear) begin
      peak_strobe_reg <= 1'b0;
    end else if (enable) begin
      peak_strobe_reg <= is_peak;
      if (is_peak) begin
        peak_mag_reg <= m1_reg;
      end
    end
  end

  // FSM state, run length and sticky detect registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      peak_count_reg <= '0;
      detected_reg   <= 1'b0;
    end else if (clear) begin
      state_reg      <= IDLE;
      peak_count_reg <= '0;
      detected_reg   <= 1'b0;
    end else if (enable) begin
      state_reg      <= state_next;
      peak_count_reg <= peak_count_next;
      detected_reg   <= detected_next;
    end
  end

  // Next-state logic: peaks extend or restart the run, a long silence ends it.
  always_comb begin
    state_next      = state_reg;
    peak_count_next = peak_count_reg;
    detected_next   = detected_reg;
    if (is_peak) begin
      case (state_reg)
        IDLE: begin
          state_next      = TRACK;
          peak_count_next = CNT_W'(1);
        end
        TRACK: begin
          if (gap_in_range) begin
            peak_count_next = cnt_inc;
            if (cnt_inc == MIN_CNT) begin
              state_next    = DETECTED;
              detected_next = 1'b1;
            end
          end else begin
            peak_count_next = CNT_W'(1);
          end
        end
        DETECTED: begin
          peak_count_next = gap_in_range ? cnt_inc : CNT_W'(1);
        end
        default: begin
          state_next      = IDLE;
          peak_count_next = '0;
        end
      endcase
    end else if (gap_timeout) begin
      case (state_reg)
        TRACK: begin
          state_next      = IDLE;
          peak_count_next = '0;
        end
        DETECTED: begin
          peak_count_next = '0;
        end
        default: begin
          peak_count_next = peak_count_reg;
        end
      endcase
    end
  end

  assign peak_strobe = peak_strobe_reg & enable;
  assign peak_mag    = peak_mag_reg;
  assign peak_count  = peak_count_reg;
  assign detected    = detected_reg;

endmodule

// File: tb/tb_corr_peak_detect.sv
// Directed bench for corr_peak_detect with hand-computed expectations.
module tb_corr_peak_detect;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] threshold = 32'd1000;
  logic [63:0] sum_in = '0;
  logic        sum_strobe = 1'b0;
  logic        peak_strobe;
  logic [32:0] peak_mag;
  logic [3:0]  peak_count;
  logic        detected;

  int checks = 0;
  int errors = 0;

  logic [63:0] stim[$];
  logic        obs_strobe [0:255];
  logic [32:0] obs_mag    [0:255];
  logic [3:0]  obs_cnt    [0:255];
  logic        obs_det    [0:255];

  corr_peak_detect #(.PEAK_GAP(16), .GAP_TOL(1), .MIN_PEAKS(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .threshold   (threshold),
    .sum_in      (sum_in),
    .sum_strobe  (sum_strobe),
    .peak_strobe (peak_strobe),
    .peak_mag    (peak_mag),
    .peak_count  (peak_count),
    .detected    (detected)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] mk(input logic [31:0] i, input logic [31:0] q);
    return {i, q};
  endfunction

  // Drive one cycle of input, then return 1 time unit after the rising edge.
  task automatic step(input logic [63:0] s, input logic stb);
    sum_in = s;
    sum_strobe = stb;
    @(posedge clock);
    #1;
  endtask

  // Feed stim[] one sample per cycle; obs[i] is captured just after sample i's edge.
  task automatic play();
    for (int i = 0; i < stim.size() && i < 256; i++) begin
      step(stim[i], 1'b1);
      obs_strobe[i] = peak_strobe;
      obs_mag[i]    = peak_mag;
      obs_cnt[i]    = peak_count;
      obs_det[i]    = detected;
    end
    sum_strobe = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step('0, 1'b0);
    clear = 1'b0;
  endtask

  // Stream of n samples, magnitude 5000 at the listed indices (-1 = unused), 0 elsewhere.
  task automatic build(input int n, input int p0, input int p1, input int p2);
    stim.delete();
    for (int i = 0; i < n; i++) begin
      stim.push_back((i == p0 || i == p1 || i == p2) ? mk(32'd5000, 32'd0) : 64'd0);
    end
  endtask

  function automatic int count_strobes(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (obs_strobe[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    logic [35:0] outs;
    @(posedge clock);
    #1;
    for (int i = 0; i < 6; i++) begin
      step({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      outs = {peak_strobe, peak_mag, peak_count, detected} & 36'hF_FFFF_FFFF;
      checks++;
      if ({peak_strobe, peak_mag, peak_count, detected} !== 39'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %0h expected 0", i, outs);
      end
    end
    // Release with a large strobed sample that must be dropped.
    reset_n = 1'b1;
    step(mk(32'd9000, 32'd0), 1'b1);
    for (int i = 0; i < 12; i++) begin
      step('0, 1'b1);
      checks++;
      if (peak_strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_no_peak cycle %0d: got %0b expected 0", i, peak_strobe);
      end
    end
    sum_strobe = 1'b0;
  endtask

  task automatic test_magnitude();
    logic [31:0] vi [4];
    logic [31:0] vq [4];
    logic [32:0] ve [4];
    vi = '{32'hFFFF_FFFB, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    vq = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    ve = '{33'd12, 33'h1_0000_0000, 33'h0_8000_0000, 33'h0_8000_0000};
    threshold = 32'd0;
    for (int k = 0; k < 4; k++) begin
      do_clear();
      stim.delete();
      stim.push_back(64'd0);
      stim.push_back(mk(vi[k], vq[k]));
      stim.push_back(64'd0);
      stim.push_back(64'd0);
      play();
      checks++;
      if (obs_strobe[3] !== 1'b1 || count_strobes(4) != 1) begin
        errors++;
        $display("FAIL mag_peak_strobe vec %0d: got strobe %0b count %0d expected 1 at sample 3",
                 k, obs_strobe[3], count_strobes(4));
      end
      checks++;
      if (obs_mag[3] !== ve[k]) begin
        errors++;
        $display("FAIL mag_value vec %0d: got %0h expected %0h", k, obs_mag[3], ve[k]);
      end
    end
    threshold = 32'd1000;
  endtask

  task automatic test_plateau_threshold();
    do_clear();
    stim = '{64'd0, mk(32'd5000, 32'd0), mk(32'd5000, 32'd0), 64'd0, 64'd0, 64'd0};
    play();
    checks++;
    if (count_strobes(6) != 1 || obs_strobe[4] !== 1'b1) begin
      errors++;
      $display("FAIL plateau_one_peak: got %0d peaks (strobe@4=%0b) expected 1 at 4",
               count_strobes(6), obs_strobe[4]);
    end
    checks++;
    if (obs_mag[4] !== 33'd5000 || obs_cnt[4] !== 4'd1) begin
      errors++;
      $display("FAIL plateau_mag: got mag %0d cnt %0d expected 5000 cnt 1", obs_mag[4], obs_cnt[4]);
    end
    do_clear();
    stim = '{64'd0, mk(32'd1000, 32'd0), 64'd0, 64'd0, 64'd0};
    play();
    checks++;
    if (count_strobes(5) != 0) begin
      errors++;
      $display("FAIL threshold_equal_no_peak: got %0d peaks expected 0", count_strobes(5));
    end
    do_clear();
    stim = '{64'd0, mk(32'd1001, 32'd0), 64'd0, 64'd0, 64'd0};
    play();
    checks++;
    if (count_strobes(5) != 1 || obs_mag[3] !== 33'd1001) begin
      errors++;
      $display("FAIL threshold_above_peak: got %0d peaks mag %0d expected 1 peak mag 1001",
               count_strobes(5), obs_mag[3]);
    end
  endtask

  task automatic test_detect();
    int bad;
    do_clear();
    build(150, 10, 26, 42);
    play();
    checks++;
    if (count_strobes(150) != 3) begin
      errors++;
      $display("FAIL detect_peak_total: got %0d expected 3", count_strobes(150));
    end
    checks++;
    if (obs_strobe[12] !== 1'b1 || obs_cnt[12] !== 4'd1) begin
      errors++;
      $display("FAIL detect_peak1: got strobe %0b cnt %0d expected 1 cnt 1", obs_strobe[12], obs_cnt[12]);
    end
    checks++;
    if (obs_strobe[28] !== 1'b1 || obs_cnt[28] !== 4'd2) begin
      errors++;
      $display("FAIL detect_peak2: got strobe %0b cnt %0d expected 1 cnt 2", obs_strobe[28], obs_cnt[28]);
    end
    checks++;
    if (obs_strobe[44] !== 1'b1 || obs_cnt[44] !== 4'd3 || obs_mag[44] !== 33'd5000) begin
      errors++;
      $display("FAIL detect_peak3: got strobe %0b cnt %0d mag %0d expected 1 cnt 3 mag 5000",
               obs_strobe[44], obs_cnt[44], obs_mag[44]);
    end
    checks++;
    if (obs_det[43] !== 1'b0 || obs_det[44] !== 1'b1) begin
      errors++;
      $display("FAIL detect_rise: got det@43 %0b det@44 %0b expected 0 then 1", obs_det[43], obs_det[44]);
    end
    bad = 0;
    for (int i = 44; i < 150; i++) if (obs_det[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL detect_sticky: got %0d samples low expected 0", bad);
    end
    checks++;
    if (obs_cnt[61] !== 4'd3 || obs_cnt[62] !== 4'd0) begin
      errors++;
      $display("FAIL detect_timeout_cnt: got cnt@61 %0d cnt@62 %0d expected 3 then 0", obs_cnt[61], obs_cnt[62]);
    end
  endtask

  task automatic test_spacing_break();
    int dets;
    do_clear();
    build(80, 10, 26, 46);
    play();
    dets = 0;
    for (int i = 0; i < 80; i++) if (obs_det[i] !== 1'b0) dets++;
    checks++;
    if (count_strobes(80) != 3 || obs_cnt[12] !== 4'd1 || obs_cnt[28] !== 4'd2 || obs_cnt[48] !== 4'd1
        || obs_strobe[48] !== 1'b1) begin
      errors++;
      $display("FAIL break_counts: got peaks %0d cnts %0d %0d %0d expected 3 peaks cnts 1 2 1",
               count_strobes(80), obs_cnt[12], obs_cnt[28], obs_cnt[48]);
    end
    checks++;
    if (dets != 0) begin
      errors++;
      $display("FAIL break_no_detect: got %0d detected samples expected 0", dets);
    end
    checks++;
    if (obs_cnt[45] !== 4'd2 || obs_cnt[46] !== 4'd0) begin
      errors++;
      $display("FAIL break_timeout_gap18: got cnt@45 %0d cnt@46 %0d expected 2 then 0", obs_cnt[45], obs_cnt[46]);
    end
    checks++;
    if (obs_cnt[65] !== 4'd1 || obs_cnt[66] !== 4'd0) begin
      errors++;
      $display("FAIL break_final_idle: got cnt@65 %0d cnt@66 %0d expected 1 then 0", obs_cnt[65], obs_cnt[66]);
    end
    // Gap of 14 restarts the run without a timeout.
    do_clear();
    build(60, 10, 26, 40);
    play();
    checks++;
    if (obs_strobe[42] !== 1'b1 || obs_cnt[42] !== 4'd1 || obs_cnt[41] !== 4'd2 || obs_det[59] !== 1'b0) begin
      errors++;
      $display("FAIL short_gap_restart: got strobe %0b cnt@41 %0d cnt@42 %0d det %0b expected 1 2 1 0",
               obs_strobe[42], obs_cnt[41], obs_cnt[42], obs_det[59]);
    end
    // Gaps of 15 and 17 sit on the tolerance edges and still count.
    do_clear();
    build(60, 10, 25, 42);
    play();
    checks++;
    if (obs_cnt[27] !== 4'd2 || obs_cnt[44] !== 4'd3 || obs_det[43] !== 1'b0 || obs_det[44] !== 1'b1) begin
      errors++;
      $display("FAIL tolerance_edges: got cnt@27 %0d cnt@44 %0d det %0b%0b expected 2 3 det 01",
               obs_cnt[27], obs_cnt[44], obs_det[43], obs_det[44]);
    end
  endtask

  task automatic test_control();
    // Clear while DETECTED
    do_clear();
    build(50, 10, 26, 42);
    play();
    checks++;
    if (obs_det[49] !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_pre_detect: got %0b expected 1", obs_det[49]);
    end
    clear = 1'b1;
    step('0, 1'b0);
    clear = 1'b0;
    checks++;
    if (detected !== 1'b0 || peak_count !== 4'd0 || peak_mag !== 33'd5000) begin
      errors++;
      $display("FAIL ctrl_clear: got det %0b cnt %0d mag %0d expected 0 0 5000", detected, peak_count, peak_mag);
    end

    // Enable low for 8 cycles mid-TRACK freezes everything, including the gap.
    do_clear();
    build(21, 10, -1, -1);
    play();
    checks++;
    if (peak_count !== 4'd1) begin
      errors++;
      $display("FAIL ctrl_pre_freeze: got cnt %0d expected 1", peak_count);
    end
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step({$urandom, $urandom}, 1'b1);
      checks++;
      if (peak_strobe !== 1'b0 || peak_count !== 4'd1 || detected !== 1'b0 || peak_mag !== 33'd5000) begin
        errors++;
        $display("FAIL ctrl_freeze cycle %0d: got strobe %0b cnt %0d det %0b mag %0d expected 0 1 0 5000",
                 i, peak_strobe, peak_count, detected, peak_mag);
      end
    end
    enable = 1'b1;
    stim.delete();
    for (int s = 21; s <= 30; s++) stim.push_back((s == 26) ? mk(32'd5000, 32'd0) : 64'd0);
    play();
    checks++;
    if (count_strobes(10) != 1 || obs_strobe[7] !== 1'b1 || obs_cnt[7] !== 4'd2) begin
      errors++;
      $display("FAIL ctrl_after_freeze: got peaks %0d strobe@7 %0b cnt %0d expected 1 1 2",
               count_strobes(10), obs_strobe[7], obs_cnt[7]);
    end

    // Asynchronous reset mid-TRACK
    do_clear();
    build(21, 10, -1, -1);
    play();
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (peak_strobe !== 1'b0 || peak_count !== 4'd0 || peak_mag !== 33'd0 || detected !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_async_reset: got strobe %0b cnt %0d mag %0d det %0b expected all 0",
               peak_strobe, peak_count, peak_mag, detected);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step('0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_magnitude();
    test_plateau_threshold();
    test_detect();
    test_spacing_break();
    test_control();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/corr_peak_detect.md
# corr_peak_detect

Consumer of the 8-tap complex correlator's 64-bit sum stream. Converts each strobed correlation sum into a magnitude, finds local maxima above a programmable threshold, and tracks whether successive peaks recur at the expected sample spacing. After `MIN_PEAKS` consecutive well-spaced peaks it asserts `detected`, giving the receiver front end a preamble-detect indication.

## Interface
- `PEAK_GAP`, 16: expected spacing between peaks, in samples.
- `GAP_TOL`, 1: allowed ± deviation from `PEAK_GAP`.
- `MIN_PEAKS`, 3: number of consecutive well-spaced peaks required for detect; range 2..15.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  advances state only when high; when low, all registers hold and output strobes read 0.
- `clear`  in  1  synchronous flush; takes priority over `enable` and all inputs.
- `threshold`  in  32  unsigned peak threshold, zero-extended to 33 bits for comparison.
- `sum_in`  in  64  I in [63:32], Q in [31:0], both signed two's complement.
- `sum_strobe`  in  1  `sum_in` valid this cycle.
- `peak_strobe`  out  1  one-cycle pulse for each accepted peak.
- `peak_mag`  out  33  magnitude of the peak; held until the next peak.
- `peak_count`  out  4  current run length of well-spaced peaks, saturating at 15.
- `detected`  out  1  sticky detect flag.

## Operation
- **Stage M (magnitude).** On `sum_strobe`, register mag = |I| + |Q| as 33-bit unsigned. |−2^31| = 2^31 exactly; no saturation. Register `mag_valid` alongside.
- **History.** On each `mag_valid`, shift m2 ← m1 and m1 ← mag. All history is 0 after reset or `clear`.
- **Peak decision.** Evaluated on `mag_valid` cycles only. A peak at m1 requires all of:
  - m1 > threshold
  - m1 ≥ m2
  - m1 > mag

  Plateaus therefore yield exactly one peak, on the last equal sample before the fall.
- **Gap counter.** Cleared to 0 on every peak decision. Incremented on each `mag_valid`, saturating at 255. At a `mag_valid` cycle, the candidate gap is `gap_cnt` + 1.
- **FSM states:** IDLE, TRACK, DETECTED.
  - IDLE, on peak: go to TRACK, `peak_count` = 1.
  - TRACK, on peak with gap in [PEAK_GAP−GAP_TOL, PEAK_GAP+GAP_TOL]: increment `peak_count`. If the result equals `MIN_PEAKS`, go to DETECTED and set `detected` = 1.
  - TRACK, on peak with gap out of range: stay in TRACK, `peak_count` = 1.
  - TRACK, when the gap exceeds PEAK_GAP+GAP_TOL with no peak: go to IDLE, `peak_count` = 0.
  - DETECTED: absorbing state. `detected` stays 1. `peak_strobe`, `peak_mag` and `peak_count` keep updating under the TRACK rules, but the state never leaves DETECTED; a timeout only zeroes `peak_count`.
  - Leave DETECTED only via `clear` or `reset_n`.
- **`clear`.** Sets state to IDLE; zeroes history, `gap_cnt`, `peak_count` and `detected`; cancels any in-flight `mag_valid`. `peak_mag` is kept.
- **Simultaneous peak and timeout.** Cannot occur on the same cycle: the peak check uses `gap_cnt` + 1 before the timeout compare.

## Timing
- **Reset values.** All outputs 0; state IDLE; history 0.
- **Latency.** `sum_strobe` in cycle t gives `mag_valid` in t+1. A peak at sample k is decided when sample k+1's magnitude is valid. With sample k+1 strobed in cycle t, `peak_strobe` and the updated `peak_mag` and `peak_count` are registered outputs visible in t+2.
- **`detected`.** Rises in the same cycle as the qualifying `peak_strobe`.
- **Back-to-back strobes.** Every-cycle `sum_strobe` is supported at full rate; there is no backpressure.
- **`reset_n` mid-operation.** Asynchronous return to reset values. A `sum_strobe` in the deassertion cycle is dropped.

## Structure
- Package `corr_pkg`: state enum (IDLE, TRACK, DETECTED), `MAG_W` = 33, `GAP_W` = 8, `CNT_W` = 4.
- Sub-module `cplx_abs_sum`: a registered |I| + |Q| stage with a valid pass-through; it is reusable elsewhere.
- Top level holds the history, the peak comparator, the gap counter and the FSM.

## Test plan
Parameters for all scenarios: `PEAK_GAP` = 16, `GAP_TOL` = 1, `MIN_PEAKS` = 3, threshold = 1000.
1. **Reset.** Hold `reset_n` low with random `sum_in` and `sum_strobe` → all outputs 0. Release → no `peak_strobe` until the first qualifying peak.
2. **Magnitude.**
   - I = −5, Q = 7 → internal mag 12.
   - I = Q = 0x8000_0000 → 0x1_0000_0000.
   - Put each value between zeros with threshold 0 → `peak_mag` equals the value.
3. **Detect.** Continuous strobes, mag 5000 at samples 10, 26, 42, 0 elsewhere.
   - `peak_strobe` occurs three times, with `peak_count` 1, 2, 3.
   - `detected` = 1 two cycles after sample 43's strobe and holds through 100 further samples.
4. **Spacing break.** Peaks at samples 10, 26, 46 (gap 20 > 17) → `peak_count` 1, 2, 1 and no detect. After no further peaks → IDLE, `peak_count` 0 at gap 18.
5. **Plateau and threshold.**
   - Sequence 0, 5000, 5000, 0 → exactly one peak, with `peak_mag` 5000.
   - Sequence 0, 1000, 0 → no peak (threshold is not exceeded).
6. **Control.**
   - In DETECTED, pulse `clear` → `detected` and `peak_count` 0 next cycle.
   - `enable` low for 8 cycles during TRACK → `gap_cnt` and all outputs frozen.
   - `reset_n` low mid-TRACK → immediate reset values.
